secp256k1_mul_arbiter: RTL and testbench

Shares one secp256k1_mul_mod_serial instance between NUM_REQ requesters, such as point-add, point-double and inversion sequencers. Grants are round-robin. The block latches the winner's operands, sequences the multiplier's start/done handshake and routes the product back to the winner with a one-hot valid. A watchdog detects a hung multiplier and parks the block in a fault state.

---
 rtl/secp256k1_mul_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_secp256k1_mul_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secp256k1_mul_arbiter.sv
// -----------------------------------------------------------------------------
// secp256k1_mul_arbiter
//
// Shares one secp256k1_mul_mod_serial multiplier between NUM_REQ requesters
// (point-add, point-double, inversion sequencers, ...). Grants rotate
// round-robin. The winner's operands are latched, the multiplier start/done
// handshake is sequenced, and the product is returned to the winner with a
// one-cycle one-hot valid. A watchdog parks the block in FAULT if the
// multiplier never answers.
//
// Ports
//   clk, rst_n       clock (posedge) and asynchronous active-low reset
//   req_valid        per-requester request
//   req_a, req_b     packed operands, requester i at [256*i+255 : 256*i]
//   req_ready        one-hot accept, combinational, only in IDLE
//   rsp_valid        one-hot, one-cycle, registered response strobe
//   rsp_result       product for the requester flagged by rsp_valid
//   mul_start        registered start pulse to the multiplier
//   mul_a, mul_b     latched operands, stable from accept until mul_done
//   mul_result       product from the multiplier
//   mul_done         one-cycle completion pulse from the multiplier
//   busy             high whenever the FSM is not in IDLE
//   fault            sticky watchdog flag
//   op_count         completed operations, saturating
// -----------------------------------------------------------------------------
module secp256k1_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*256-1:0] req_a,
   input  logic [NUM_REQ*256-1:0] req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [255:0]           rsp_result,
   output logic                   mul_start,
   output logic [255:0]           mul_a,
   output logic [255:0]           mul_b,
   input  logic [255:0]           mul_result,
   input  logic                   mul_done,
   output logic                   busy,
   output logic                   fault,
   output logic [CNT_W-1:0]       op_count
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_grant;
   logic               r_mul_start;
   logic [255:0]       r_mul_a;
   logic [255:0]       r_mul_b;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [255:0]       r_rsp_result;
   logic               r_fault;
   logic [CNT_W-1:0]   r_op_count;
   logic [TMR_W-1:0]   r_timer;

   logic [NUM_REQ-1:0] w_rot;
   logic               w_any;
   logic [IDX_W-1:0]   w_off;
   logic [IDX_W:0]     w_sum;
   logic [IDX_W-1:0]   w_win;
   logic [IDX_W-1:0]   w_win_nxt;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [NUM_REQ-1:0] w_grant_oh;
   logic [255:0]       w_sel_a;
   logic [255:0]       w_sel_b;

   // Round-robin winner: rotate the request vector so rr_ptr sits at bit 0,
   // take the lowest set bit, then rotate the offset back modulo NUM_REQ.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
      w_any = |w_rot;
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = IDX_W'(k);
      end
      w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      w_win     = w_sum[IDX_W-1:0];
      w_win_nxt = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);

      w_win_oh          = '0;
      w_win_oh[w_win]   = 1'b1;
      w_grant_oh        = '0;
      w_grant_oh[r_grant] = 1'b1;

      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == IDX_W'(i)) begin
            w_sel_a = req_a[256*i +: 256];
            w_sel_b = req_b[256*i +: 256];
         end
      end
   end

   // FSM next state and the combinational accept.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               req_ready   = w_win_oh;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (mul_done)                 w_state_nxt = S_IDLE;
            else if (r_timer == TMR_LAST) w_state_nxt = S_FAULT;
         end
         S_FAULT: w_state_nxt = S_FAULT;  // only rst_n leaves FAULT
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the wide operand/result registers are reset as well, so nothing downstream ever sees X after reset.
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_mul_start  <= 1'b0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_fault      <= 1'b0;
         r_op_count   <= '0;
         r_timer      <= '0;
      end else begin
         // Both strobes are single-cycle pulses.
         r_mul_start <= 1'b0;
         r_rsp_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_mul_a     <= w_sel_a;
                  r_mul_b     <= w_sel_b;
                  r_grant     <= w_win;
                  r_rr_ptr    <= w_win_nxt;
                  r_mul_start <= 1'b1;
               end
            end
            S_ISSUE: r_timer <= '0;
            S_WAIT: begin
               r_timer <= r_timer + TMR_W'(1);
               if (mul_done) begin
                  r_rsp_result <= mul_result;
                  r_rsp_valid  <= w_grant_oh;
                  if (r_op_count != {CNT_W{1'b1}}) r_op_count <= r_op_count + CNT_W'(1);
               end else if (r_timer == TMR_LAST) begin
                  r_fault <= 1'b1;
               end
            end
            default: ;  // FAULT holds everything
         endcase
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign fault      = r_fault;
   assign mul_start  = r_mul_start;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_secp256k1_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_secp256k1_mul_arbiter
//
// Bench for secp256k1_mul_arbiter with NUM_REQ=4, TIMEOUT=16, CNT_W=4 and a
// stub multiplier of fixed 10-cycle latency (or hung). Expected responses
// are queued when a request is accepted and compared when rsp_valid fires.
// -----------------------------------------------------------------------------
module tb_secp256k1_mul_arbiter;

   localparam int NR = 4;
   localparam logic [255:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [255:0] TWO256 = 256'h1_000003D1;  // 2^256 mod p

   typedef struct {
      int           idx;
      logic [255:0] a;
      logic [255:0] b;
      logic [255:0] exp;
   } vec_t;

   typedef struct {
      logic [NR-1:0] oh;
      logic [255:0]  res;
   } sb_t;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*256-1:0] req_a;
   logic [NR*256-1:0] req_b;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [255:0]      rsp_result;
   logic              mul_start;
   logic [255:0]      mul_a;
   logic [255:0]      mul_b;
   logic [255:0]      mul_result;
   logic              mul_done;
   logic              busy;
   logic              fault;
   logic [3:0]        op_count;

   secp256k1_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT(16), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .busy       (busy),
      .fault      (fault),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub multiplier: latches (a*b) mod p on start, pulses done 10 cycles later.
   logic         stub_hang;
   logic         stray_done;
   logic [7:0]   stub_cnt;
   logic [255:0] stub_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stub_cnt <= 8'd0;
         stub_res <= '0;
      end else if (mul_start) begin
         stub_cnt <= stub_hang ? 8'd0 : 8'd10;
         stub_res <= 256'((512'(mul_a) * 512'(mul_b)) % 512'(P));
      end else if (stub_cnt != 8'd0) begin
         stub_cnt <= stub_cnt - 8'd1;
      end
   end

   assign mul_done   = stray_done | (stub_cnt == 8'd1);
   assign mul_result = stub_res;

   // Bookkeeping
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           n_start  = 0;
   int           acc_log[$];
   int           acc_cyc[$];
   int           rsp_cyc[$];
   sb_t          sb[$];
   logic [255:0] exp_res [NR];
   logic [NR-1:0] last_acc;
   logic [NR-1:0] hold;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: log accepts, push expectations, score responses.
   always @(negedge clk) begin
      logic [NR-1:0] acc;
      int            g;
      sb_t           ent;
      cyc++;
      if (rst_n) begin
         acc      = req_valid & req_ready;
         last_acc = acc;
         g        = 0;
         if (acc != '0) begin
            for (int i = 0; i < NR; i++) if (acc[i]) g = i;
            acc_log.push_back(g);
            acc_cyc.push_back(cyc);
            ent.oh  = acc;
            ent.res = exp_res[g];
            sb.push_back(ent);
         end
         if (mul_start) n_start++;
         if (rsp_valid != '0) begin
            rsp_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check("rsp_unexpected", 256'(rsp_valid), 256'd0);
            end else begin
               ent = sb.pop_front();
               check("rsp_valid", 256'(rsp_valid), 256'(ent.oh));
               check("rsp_result", rsp_result, ent.res);
            end
         end
         check("ready_only_idle", 256'(busy && (req_ready != '0)), 256'd0);
      end else begin
         last_acc = '0;
         sb.delete();  // in-flight results are discarded by reset
      end
   end

   // One clock: advance past posedge and retire accepted, non-held requests.
   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(last_acc & ~hold);
   endtask

   task automatic drive(input int idx, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] e);
      req_a[256*idx +: 256] = a;
      req_b[256*idx +: 256] = b;
      exp_res[idx]          = e;
      req_valid[idx]        = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      bit done = 0;
      while (!done && n < 300) begin
         tick();
         @(negedge clk);
         n++;
         done = (req_valid == '0) && !busy && (sb.size() == 0);
      end
      if (!done) check("drain_timeout", 256'd1, 256'd0);
   endtask

   task automatic wait_accepts(input int target, input string name);
      int n = 0;
      while (acc_log.size() < target && n < 200) begin
         tick();
         @(negedge clk);
         n++;
      end
      if (acc_log.size() < target) check(name, 256'(acc_log.size()), 256'(target));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   vec_t vecs [8];
   int   ops;
   int   base;
   int   rbase;
   int   sbase;

   initial begin
      vecs[0] = '{1, 256'd2,          256'd3,          256'd6};
      vecs[1] = '{0, P - 256'd1,      P - 256'd1,      256'd1};
      vecs[2] = '{2, P - 256'd1,      256'd2,          P - 256'd2};
      vecs[3] = '{3, 256'd1 << 128,   256'd1 << 128,   TWO256};
      vecs[4] = '{1, 256'd0,          P - 256'd1,      256'd0};
      vecs[5] = '{0, 256'd1,          P - 256'd1,      P - 256'd1};
      vecs[6] = '{2, 256'd7,          256'd11,         256'd77};
      vecs[7] = '{3, 256'd1 << 255,   256'd2,          TWO256};

      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; hold = '0;
      stub_hang = 1'b0; stray_done = 1'b0; last_acc = '0;
      for (int i = 0; i < NR; i++) exp_res[i] = '0;
      ops = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_busy",      256'(busy),       256'd0);
      check("rst_fault",     256'(fault),      256'd0);
      check("rst_op_count",  256'(op_count),   256'd0);
      check("rst_mul_start", 256'(mul_start),  256'd0);
      check("rst_mul_a",     mul_a,            256'd0);
      check("rst_mul_b",     mul_b,            256'd0);
      check("rst_rsp_valid", 256'(rsp_valid),  256'd0);
      check("rst_rsp_res",   rsp_result,       256'd0);
      tick();
      rst_n = 1'b1;

      // Contention from reset: 0 and 2 together -> 0 then 2
      tick();
      base = acc_log.size();
      drive(0, vecs[5].a, vecs[5].b, vecs[5].exp);
      drive(2, vecs[6].a, vecs[6].b, vecs[6].exp);
      drain();
      ops += 2;
      check("cont_grant0", 256'(acc_log[base]),   256'd0);
      check("cont_grant1", 256'(acc_log[base+1]), 256'd2);

      // All four continuously valid: rr_ptr=3 -> 3,0,1,2
      tick();
      hold = 4'hF;
      base = acc_log.size();
      for (int i = 0; i < NR; i++) drive(i, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_accepts(base + 4, "all4_accepts");
      tick();
      req_valid = '0;
      hold      = '0;
      drain();
      ops += 4;
      check("rr_grant0", 256'(acc_log[base]),   256'd3);
      check("rr_grant1", 256'(acc_log[base+1]), 256'd0);
      check("rr_grant2", 256'(acc_log[base+2]), 256'd1);
      check("rr_grant3", 256'(acc_log[base+3]), 256'd2);

      // Basic: requester 1, 2*3
      tick();
      sbase = n_start;
      drive(1, 256'd2, 256'd3, 256'd6);
      @(negedge clk);
      check("basic_ready", 256'(req_ready), 256'(4'b0010));
      drain();
      ops += 1;
      check("basic_start_pulses", 256'(n_start - sbase), 256'd1);
      check("basic_op_count",     256'(op_count),        256'(ops));

      // Table-driven vectors, op_count saturates at 15 on the way
      for (int v = 0; v < 8; v++) begin
         tick();
         drive(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp);
         drain();
         ops += 1;
         check($sformatf("vec%0d_op_count", v), 256'(op_count), 256'((ops > 15) ? 15 : ops));
      end

      // Back-to-back: requester 3 held through 3 operations
      tick();
      hold[3] = 1'b1;
      base  = acc_log.size();
      rbase = rsp_cyc.size();
      drive(3, vecs[7].a, vecs[7].b, vecs[7].exp);
      wait_accepts(base + 3, "b2b_accepts");
      tick();
      req_valid = '0;
      hold      = '0;
      drain();
      ops += 3;
      check("b2b_gap01",  256'(acc_cyc[base+1] - acc_cyc[base]),   256'd12);
      check("b2b_gap12",  256'(acc_cyc[base+2] - acc_cyc[base+1]), 256'd12);
      check("b2b_rsp0",   256'(rsp_cyc[rbase]),                    256'(acc_cyc[base+1]));
      check("b2b_rsp1",   256'(rsp_cyc[rbase+1]),                  256'(acc_cyc[base+2]));
      check("sat_op_count", 256'(op_count), 256'd15);

      // Timeout: hung multiplier, fault on the 16th WAIT cycle
      tick();
      stub_hang = 1'b1;
      drive(2, vecs[6].a, vecs[6].b, vecs[6].exp);
      @(negedge clk);
      check("to_ready", 256'(req_ready), 256'(4'b0100));
      repeat (17) begin
         tick();
         @(negedge clk);
      end
      check("to_fault_before", 256'(fault), 256'd0);
      tick();
      @(negedge clk);
      check("to_fault_set", 256'(fault), 256'd1);
      tick();
      for (int i = 0; i < NR; i++) drive(i, vecs[i].a, vecs[i].b, vecs[i].exp);
      repeat (6) begin
         tick();
         @(negedge clk);
         check("fault_ready", 256'(req_ready), 256'd0);
         check("fault_rsp",   256'(rsp_valid), 256'd0);
         check("fault_busy",  256'(busy),      256'd1);
      end
      tick();
      rst_n = 1'b0; req_valid = '0; stub_hang = 1'b0;
      @(negedge clk);
      check("fault_cleared",   256'(fault),    256'd0);
      check("fault_rst_busy",  256'(busy),     256'd0);
      check("fault_rst_count", 256'(op_count), 256'd0);
      tick();
      rst_n = 1'b1;
      ops = 0;

      // Reset mid-operation, then a stray done
      tick();
      drive(1, vecs[0].a, vecs[0].b, vecs[0].exp);
      repeat (5) begin
         tick();
         @(negedge clk);
      end
      check("midop_busy", 256'(busy), 256'd1);
      tick();
      rst_n = 1'b0;
      #2;
      check("midop_busy_rst",  256'(busy),      256'd0);
      check("midop_start_rst", 256'(mul_start), 256'd0);
      check("midop_a_rst",     mul_a,           256'd0);
      check("midop_b_rst",     mul_b,           256'd0);
      check("midop_rsp_rst",   256'(rsp_valid), 256'd0);
      check("midop_res_rst",   rsp_result,      256'd0);
      check("midop_ready_rst", 256'(req_ready), 256'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();
      stray_done = 1'b1;
      @(negedge clk);
      check("stray_rsp",  256'(rsp_valid), 256'd0);
      check("stray_busy", 256'(busy),      256'd0);
      tick();
      stray_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stray_rsp_after", 256'(rsp_valid), 256'd0);
         tick();
      end
      base = acc_log.size();
      drive(2, vecs[2].a, vecs[2].b, vecs[2].exp);
      drain();
      check("post_rst_grant", 256'(acc_log[base]), 256'd2);
      check("post_rst_count", 256'(op_count),      256'd1);
      check("sb_empty",       256'(sb.size()),     256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
